mem8_transpose_ctrl: RTL and testbench

//  Sequencer on both ports of the 64-entry mem8 block buffer. Accepts one 8x8

---
 rtl/idct_pkg.sv | 25 ++
 rtl/mem8_transpose_ctrl.sv | 120 ++++++++++++
 tb/tb_mem8_transpose_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/idct_pkg.sv
// Shared constants, state encoding and address helper for the IDCT block path.
package idct_pkg;

    localparam int BLK_N    = 8;
    localparam int BLK_SZ   = BLK_N * BLK_N;
    localparam int ADDR_W   = 6;
    localparam int CNT_W    = ADDR_W + 1;
    localparam int FIELD_W  = $clog2(BLK_N);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } xpose_state_t;

    // Buffer address for linear sample index cnt. Transposed order swaps the
    // row and column fields so a row-major block is read column by column.
    function automatic logic [ADDR_W-1:0] xpose_addr(input logic [ADDR_W-1:0] cnt,
                                                     input logic              transpose);
        if (transpose)
            return {cnt[FIELD_W-1:0], cnt[ADDR_W-1:FIELD_W]};
        else
            return cnt;
    endfunction

endpackage

// File: rtl/mem8_transpose_ctrl.sv
// Sequencer for the 64-entry mem8 block buffer: fills one 8x8 block in
// row-major order, then streams it back out (transposed or straight) with
// valid/ready flow control. The buffer itself lives in the parent.
module mem8_transpose_ctrl
    import idct_pkg::*;
#(
    parameter int WIDTH_X   = 16,
    parameter bit TRANSPOSE = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH_X-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH_X-1:0] out_data,
    output logic               out_last,
    output logic               busy,
    output logic               mem_w_en,
    output logic [ADDR_W-1:0]  mem_w_addr,
    output logic [WIDTH_X-1:0] mem_d_in,
    output logic               mem_r_en,
    output logic [ADDR_W-1:0]  mem_r_addr,
    input  logic [WIDTH_X-1:0] mem_d_out
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLK_SZ - 1);
    localparam logic [CNT_W-1:0] BLK_CNT  = CNT_W'(BLK_SZ);

    xpose_state_t     state_q,     state_d;
    logic [CNT_W-1:0] wr_cnt_q,    wr_cnt_d;
    logic [CNT_W-1:0] rd_cnt_q,    rd_cnt_d;
    logic [CNT_W-1:0] out_cnt_q,   out_cnt_d;
    logic             out_valid_q, out_valid_d;

    logic rd_issue;
    logic out_hs;

    // Next-state, counter updates and all memory/stream controls.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        out_cnt_d   = out_cnt_q;
        out_valid_d = out_valid_q;

        in_ready   = (state_q == FILL);
        busy       = (state_q == DRAIN);
        mem_w_en   = in_valid & in_ready;
        mem_w_addr = wr_cnt_q[ADDR_W-1:0];
        mem_d_in   = in_data;

        // A new read is only issued when the output register is free or is
        // being emptied this cycle; mem8 holds d_out otherwise.
        rd_issue   = (state_q == DRAIN) & (rd_cnt_q < BLK_CNT) & (~out_valid_q | out_ready);
        mem_r_en   = rd_issue;
        mem_r_addr = xpose_addr(rd_cnt_q[ADDR_W-1:0], TRANSPOSE);

        out_hs   = out_valid_q & out_ready;
        out_last = out_valid_q & (out_cnt_q == LAST_IDX);

        case (state_q)
            FILL: begin
                if (mem_w_en) begin
                    if (wr_cnt_q == LAST_IDX) begin
                        wr_cnt_d = '0;
                        state_d  = DRAIN;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (rd_issue) begin
                    rd_cnt_d    = rd_cnt_q + 1'b1;
                    out_valid_d = 1'b1;
                end else if (out_hs) begin
                    out_valid_d = 1'b0;
                end
                if (out_hs) begin
                    if (out_cnt_q == LAST_IDX) begin
                        state_d     = FILL;
                        rd_cnt_d    = '0;
                        out_cnt_d   = '0;
                        out_valid_d = 1'b0;
                    end else begin
                        out_cnt_d = out_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its _d value from before this edge.
        if (!rst_n) begin
            state_q     <= FILL;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            out_cnt_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            out_cnt_q   <= out_cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = mem_d_out;

endmodule

// File: tb/tb_mem8_transpose_ctrl.sv
// Bench for mem8_transpose_ctrl: two controllers (transposed and straight
// order) driven by the same stimulus, each with its own mem8-style buffer.
module tb_mem8_transpose_ctrl;
    import idct_pkg::*;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid, out_ready;
    logic [W-1:0] in_data;

    always #5 clk = ~clk;

    logic              in_ready_t, out_valid_t, out_last_t, busy_t, w_en_t, r_en_t;
    logic [W-1:0]      out_data_t, d_in_t, d_out_t;
    logic [ADDR_W-1:0] w_addr_t, r_addr_t;
    logic              in_ready_p, out_valid_p, out_last_p, busy_p, w_en_p, r_en_p;
    logic [W-1:0]      out_data_p, d_in_p, d_out_p;
    logic [ADDR_W-1:0] w_addr_p, r_addr_p;

    mem8_transpose_ctrl #(.WIDTH_X(W), .TRANSPOSE(1'b1)) dut_t (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_t), .in_data(in_data),
        .out_valid(out_valid_t), .out_ready(out_ready), .out_data(out_data_t),
        .out_last(out_last_t), .busy(busy_t),
        .mem_w_en(w_en_t), .mem_w_addr(w_addr_t), .mem_d_in(d_in_t),
        .mem_r_en(r_en_t), .mem_r_addr(r_addr_t), .mem_d_out(d_out_t)
    );

    mem8_transpose_ctrl #(.WIDTH_X(W), .TRANSPOSE(1'b0)) dut_p (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_p), .in_data(in_data),
        .out_valid(out_valid_p), .out_ready(out_ready), .out_data(out_data_p),
        .out_last(out_last_p), .busy(busy_p),
        .mem_w_en(w_en_p), .mem_w_addr(w_addr_p), .mem_d_in(d_in_p),
        .mem_r_en(r_en_p), .mem_r_addr(r_addr_p), .mem_d_out(d_out_p)
    );

    // mem8 models: registered read, d_out held while r_en is low.
    logic [W-1:0] mem_t [BLK_SZ];
    logic [W-1:0] mem_p [BLK_SZ];

    always @(posedge clk) begin
        if (w_en_t) mem_t[w_addr_t] <= d_in_t;
        if (r_en_t) d_out_t <= mem_t[r_addr_t];
        if (w_en_p) mem_p[w_addr_p] <= d_in_p;
        if (r_en_p) d_out_p <= mem_p[r_addr_p];
    end

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int last_acc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // No buffer writes may happen while a block is draining.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && busy_t === 1'b1) check("no_write_busy_t", w_en_t, 0);
        if (rst_n === 1'b1 && busy_p === 1'b1) check("no_write_busy_p", w_en_p, 0);
    end

    typedef struct {
        logic         in_valid;
        logic [W-1:0] in_data;
        logic         exp_in_ready;
        logic         exp_w_en;
        logic [5:0]   exp_w_addr;
        logic         exp_busy;
        logic         exp_out_valid;
        logic         exp_r_en;
    } vec_t;

    vec_t vt[6];

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (n) @(negedge clk);
        check("rst_out_valid", out_valid_t, 0);
        check("rst_in_ready",  in_ready_t, 1);
        check("rst_busy",      busy_t, 0);
        check("rst_out_last",  out_last_t, 0);
        check("rst_r_en",      r_en_t, 0);
        check("rst_w_addr",    w_addr_t, 0);
        rst_n = 1'b1;
    endtask

    task automatic feed(input int base, input int gap_pct, input bit hold);
        int idx = 0;
        int budget = 0;
        while (idx < BLK_SZ && budget < 5000) begin
            @(negedge clk);
            budget++;
            in_valid = ($urandom_range(99) >= gap_pct);
            in_data  = W'(base + idx);
            if (in_valid && in_ready_t) begin
                if (idx == BLK_SZ - 1) last_acc_cyc = cyc + 1;
                idx++;
            end
        end
        if (idx < BLK_SZ) check("feed_timeout", idx, BLK_SZ);
        @(negedge clk);
        in_valid = hold;
        in_data  = 16'hDEAD;
    endtask

    task automatic collect(input int base, input int n, input int ready_pct,
                           input bit drop_in, input bit chk_timing);
        int j = 0;
        int budget = 0;
        int first_v = -1;
        int first_hs = -1;
        int last_hs = -1;
        logic pv = 1'b0;
        logic pr = 1'b0;
        logic [W-1:0] pd = '0;
        logic [W-1:0] exp_t, exp_p;
        while (j < n && budget < 20000) begin
            @(negedge clk);
            budget++;
            if (pv && !pr) begin
                check("stall_valid", out_valid_t, 1);
                check("stall_data", out_data_t, pd);
            end
            if (out_valid_t && first_v < 0) first_v = cyc;
            pv = out_valid_t;
            pd = out_data_t;
            pr = ($urandom_range(99) < ready_pct);
            out_ready = pr;
            if (out_valid_t) check("valid_match_p", out_valid_p, 1);
            if (out_valid_t && pr) begin
                exp_t = W'(base + (j % BLK_N) * BLK_N + j / BLK_N);
                exp_p = W'(base + j);
                check("data_transposed", out_data_t, exp_t);
                check("data_straight",   out_data_p, exp_p);
                check("out_last",        out_last_t, (j == BLK_SZ - 1));
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                if (j == BLK_SZ - 1 && drop_in) in_valid = 1'b0;
                j++;
            end
        end
        if (j < n) check("collect_timeout", j, n);
        if (chk_timing) begin
            check("first_valid_latency", first_v - last_acc_cyc, 1);
            check("burst_len", last_hs - first_hs, BLK_SZ - 1);
        end
        if (n == BLK_SZ) begin
            @(negedge clk);
            out_ready = 1'b0;
            check("in_ready_after", in_ready_t, 1);
            check("out_valid_after", out_valid_t, 0);
            check("busy_after", busy_t, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // in_valid, in_data, in_ready, w_en, w_addr, busy, out_valid, r_en
        vt[0] = '{1'b0, 16'h0005, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0};
        vt[1] = '{1'b1, 16'h00AA, 1'b1, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0};
        vt[2] = '{1'b0, 16'h1234, 1'b1, 1'b0, 6'd1, 1'b0, 1'b0, 1'b0};
        vt[3] = '{1'b1, 16'h00BB, 1'b1, 1'b1, 6'd1, 1'b0, 1'b0, 1'b0};
        vt[4] = '{1'b1, 16'h00CC, 1'b1, 1'b1, 6'd2, 1'b0, 1'b0, 1'b0};
        vt[5] = '{1'b0, 16'h0000, 1'b1, 1'b0, 6'd3, 1'b0, 1'b0, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("init_out_valid", out_valid_t, 0);
        check("init_in_ready",  in_ready_t, 1);
        check("init_busy",      busy_t, 0);
        rst_n = 1'b1;

        // FILL-phase write controls, one vector per cycle.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = vt[i].in_valid;
            in_data  = vt[i].in_data;
            #1;
            check("vec_in_ready",  in_ready_t,  vt[i].exp_in_ready);
            check("vec_w_en",      w_en_t,      vt[i].exp_w_en);
            check("vec_w_addr",    w_addr_t,    vt[i].exp_w_addr);
            check("vec_d_in",      d_in_t,      vt[i].in_data);
            check("vec_busy",      busy_t,      vt[i].exp_busy);
            check("vec_out_valid", out_valid_t, vt[i].exp_out_valid);
            check("vec_r_en",      r_en_t,      vt[i].exp_r_en);
        end

        // Reset mid-FILL: next block must start again at address 0.
        do_reset(2);

        // Ramp 0..63, out_ready held high: transposed and straight order.
        fork
            feed(0, 0, 1'b0);
            collect(0, BLK_SZ, 100, 1'b0, 1'b1);
        join

        // Same block with out_ready at 30% duty.
        fork
            feed(0, 0, 1'b0);
            collect(0, BLK_SZ, 30, 1'b0, 1'b0);
        join

        // Gappy input, in_valid held through DRAIN.
        fork
            feed(0, 40, 1'b1);
            collect(0, BLK_SZ, 100, 1'b1, 1'b0);
        join

        // Reset mid-DRAIN after 20 outputs, then block B = 100..163.
        fork
            feed(500, 0, 1'b0);
            collect(500, 20, 100, 1'b0, 1'b0);
        join
        do_reset(2);
        fork
            feed(100, 0, 1'b0);
            collect(100, BLK_SZ, 100, 1'b0, 1'b1);
        join

        // Three back-to-back blocks.
        fork
            begin
                for (int b = 0; b < 3; b++) feed(1000 * (b + 1), 0, 1'b0);
            end
            begin
                for (int b = 0; b < 3; b++) collect(1000 * (b + 1), BLK_SZ, 100, 1'b0, 1'b1);
            end
        join

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
